// File: rtl/i2c_codec_responder.sv
// Write-only I2C slave that captures 7-bit codec register address + 9-bit data.
// Define I2C_GLITCH_FILTER_EN to add a 3-sample level filter on SCL/SDA.
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_sclk,
  input  logic       i2c_sdat_in,
  output logic       i2c_sdat_oe,
  output logic       reg_wr_valid,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  output logic       busy,
  output logic [7:0] wr_count
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
  } state_t;

  state_t     state;
  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl;
  logic       sda;
  logic       scl_q;
  logic       sda_q;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] byte1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], i2c_sclk};
      sda_sync <= {sda_sync[0], i2c_sdat_in};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_cnt;
  logic [1:0] sda_cnt;

  // a new level is taken on its third consecutive sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl     <= 1'b1;
      sda     <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_sync[1] == scl) begin
        scl_cnt <= '0;
      end else if (scl_cnt == 2'd2) begin
        scl     <= scl_sync[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + 2'd1;
      end
      if (sda_sync[1] == sda) begin
        sda_cnt <= '0;
      end else if (sda_cnt == 2'd2) begin
        sda     <= sda_sync[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + 2'd1;
      end
    end
  end
`else
  assign scl = scl_sync[1];
  assign sda = sda_sync[1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  logic scl_rise;
  logic scl_fall;
  logic start_c;
  logic stop_c;
  logic last_bit;

  assign scl_rise = scl & ~scl_q;
  assign scl_fall = ~scl & scl_q;
  assign start_c  = scl & scl_q & sda_q & ~sda;
  assign stop_c   = scl & scl_q & ~sda_q & sda;
  assign last_bit = scl_fall && (bit_cnt == 4'd8);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      byte1        <= '0;
      i2c_sdat_oe  <= 1'b0;
      reg_wr_valid <= 1'b0;
      reg_addr     <= '0;
      reg_data     <= '0;
      busy         <= 1'b0;
      wr_count     <= '0;
    end else begin
      reg_wr_valid <= 1'b0;
      if (start_c) begin
        state       <= ADDR;
        bit_cnt     <= '0;
        i2c_sdat_oe <= 1'b0;
        busy        <= 1'b0;
      end else if (stop_c) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        i2c_sdat_oe <= 1'b0;
        busy        <= 1'b0;
      end else begin
        unique case (state)
          ADDR: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (last_bit) begin
              bit_cnt <= '0;
              // R/W=1 also lands here: reads are not supported
              if (shreg == {DEV_ADDR, 1'b0}) begin
                state       <= ACK_A;
                i2c_sdat_oe <= 1'b1;
                busy        <= 1'b1;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ACK_A: begin
            if (scl_fall) begin
              state       <= BYTE1;
              i2c_sdat_oe <= 1'b0;
            end
          end
          BYTE1: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (last_bit) begin
              bit_cnt     <= '0;
              byte1       <= shreg;
              state       <= ACK_1;
              i2c_sdat_oe <= 1'b1;
            end
          end
          ACK_1: begin
            if (scl_fall) begin
              state       <= BYTE2;
              i2c_sdat_oe <= 1'b0;
            end
          end
          BYTE2: begin
            if (scl_rise) begin
              shreg   <= {shreg[6:0], sda};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (last_bit) begin
              bit_cnt     <= '0;
              state       <= ACK_2;
              i2c_sdat_oe <= 1'b1;
            end
          end
          ACK_2: begin
            if (scl_fall) begin
              state        <= IGNORE;
              i2c_sdat_oe  <= 1'b0;
              busy         <= 1'b0;
              reg_addr     <= byte1[7:1];
              reg_data     <= {byte1[0], shreg};
              reg_wr_valid <= 1'b1;
              wr_count     <= wr_count + 8'd1;
            end
          end
          IDLE, IGNORE: begin
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: bit-banged I2C master plus write scoreboard.
// Runs the SCL glitch case only when I2C_GLITCH_FILTER_EN is defined.
module tb_i2c_codec_responder;

`ifdef I2C_GLITCH_FILTER_EN
  localparam int LO = 7;
  localparam int HI = 4;
`else
  localparam int LO = 4;
  localparam int HI = 3;
`endif

  typedef struct packed {
    logic [6:0] a;
    logic [8:0] d;
    logic [7:0] c;
  } wr_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic       sda_line;
  logic       i2c_sdat_oe;
  logic       reg_wr_valid;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic       busy;
  logic [7:0] wr_count;

  int         total = 0;
  int         bad = 0;
  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] exp_cnt = 8'd0;
  logic       busy_seen = 1'b0;

  assign sda_line = sda_m & ~i2c_sdat_oe;

  i2c_codec_responder #(.DEV_ADDR(7'h1A)) dut (
    .clk          (clk),
    .reset        (reset),
    .i2c_sclk     (scl_m),
    .i2c_sdat_in  (sda_line),
    .i2c_sdat_oe  (i2c_sdat_oe),
    .reg_wr_valid (reg_wr_valid),
    .reg_addr     (reg_addr),
    .reg_data     (reg_data),
    .busy         (busy),
    .wr_count     (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_wr(input logic [7:0] b1, input logic [7:0] b2);
    wr_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.a = b1[7:1];
    e.d = {b1[0], b2};
    e.c = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic i2c_start();
    if (scl_m == 1'b0) begin
      w(LO - 2);
      sda_m = 1'b1;
      w(2);
      scl_m = 1'b1;
      w(HI);
    end
    sda_m = 1'b0;
    w(HI);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    w(LO - 2);
    sda_m = 1'b0;
    w(2);
    scl_m = 1'b1;
    w(HI);
    sda_m = 1'b1;
    w(HI);
  endtask

  task automatic bit_out(input logic b);
    w(LO - 2);
    sda_m = b;
    w(2);
    scl_m = 1'b1;
    w(HI);
    scl_m = 1'b0;
  endtask

  task automatic ack_slot(input logic ack, input string nm);
    w(LO - 2);
    sda_m = 1'b1;
    w(2);
    scl_m = 1'b1;
    w(HI);
    chk(nm, 32'(i2c_sdat_oe), 32'(ack));
    scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack,
                           input string nm);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    ack_slot(ack, nm);
  endtask

  task automatic wr_frame(input logic [7:0] b1, input logic [7:0] b2);
    push_wr(b1, b2);
    i2c_start();
    send_byte(8'h34, 1'b1, "ack_addr");
    chk("busy_mid", 32'(busy), 32'd1);
    send_byte(b1, 1'b1, "ack_b1");
    send_byte(b2, 1'b1, "ack_b2");
    i2c_stop();
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && reg_wr_valid) begin
      chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(reg_addr), 32'(mon_e.a));
        chk("wr_data", 32'(reg_data), 32'(mon_e.d));
        chk("wr_count", 32'(wr_count), 32'(mon_e.c));
      end
    end
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    reset = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    w(3);
    chk("rst_oe", 32'(i2c_sdat_oe), 32'd0);
    chk("rst_valid", 32'(reg_wr_valid), 32'd0);
    chk("rst_addr", 32'(reg_addr), 32'd0);
    chk("rst_data", 32'(reg_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(wr_count), 32'd0);
    reset = 1'b0;
    w(5);

    // single write: addr 0x06, data 0x000
    wr_frame(8'h0C, 8'h00);
    w(10);
    chk("count_first", 32'(wr_count), 32'd1);

    // extra byte after a complete write is NACKed
    push_wr(8'h1F, 8'hFF);
    i2c_start();
    send_byte(8'h34, 1'b1, "ack_addr2");
    send_byte(8'h1F, 1'b1, "ack_1f");
    send_byte(8'hFF, 1'b1, "ack_ff");
    send_byte(8'hAA, 1'b0, "nack_4th");
    i2c_stop();
    w(10);
    chk("addr_0f", 32'(reg_addr), 32'h0F);
    chk("data_1ff", 32'(reg_data), 32'h1FF);

    // wrong address and read request
    busy_seen = 1'b0;
    i2c_start();
    send_byte(8'h36, 1'b0, "nack_wrong_addr");
    send_byte(8'h0C, 1'b0, "nack_wrong_b1");
    i2c_stop();
    i2c_start();
    send_byte(8'h35, 1'b0, "nack_read");
    send_byte(8'h0C, 1'b0, "nack_read_b1");
    i2c_stop();
    w(10);
    chk("busy_never", 32'(busy_seen), 32'd0);
    chk("count_kept", 32'(wr_count), 32'd2);

    // aborted by STOP after byte 1
    i2c_start();
    send_byte(8'h34, 1'b1, "ack_addr_abort");
    send_byte(8'h0C, 1'b1, "ack_b1_abort");
    i2c_stop();
    w(10);
    chk("abort_addr", 32'(reg_addr), 32'h0F);
    chk("abort_data", 32'(reg_data), 32'h1FF);
    chk("abort_count", 32'(wr_count), 32'd2);

    // aborted by repeated START, then a full write
    push_wr(8'h0E, 8'h01);
    i2c_start();
    send_byte(8'h34, 1'b1, "ack_addr_rs0");
    send_byte(8'h0C, 1'b1, "ack_b1_rs0");
    i2c_start();
    send_byte(8'h34, 1'b1, "ack_addr_rs1");
    send_byte(8'h0E, 1'b1, "ack_b1_rs1");
    send_byte(8'h01, 1'b1, "ack_b2_rs1");
    i2c_stop();
    w(10);
    chk("rs_addr", 32'(reg_addr), 32'h07);
    chk("rs_data", 32'(reg_data), 32'h001);

    // reset in the middle of byte 1
    i2c_start();
    send_byte(8'h34, 1'b1, "ack_addr_rst");
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b1);
    chk("busy_byte1", 32'(busy), 32'd1);
    #3 reset = 1'b1;
    #1;
    chk("midrst_oe", 32'(i2c_sdat_oe), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_count", 32'(wr_count), 32'd0);
    chk("midrst_addr", 32'(reg_addr), 32'd0);
    chk("midrst_data", 32'(reg_data), 32'd0);
    w(2);
    reset = 1'b0;
    exp_cnt = 8'd0;
    for (int i = 0; i < 5; i++) bit_out(1'b0);
    ack_slot(1'b0, "nack_after_rst");
    send_byte(8'h00, 1'b0, "nack_after_rst_b2");
    i2c_stop();
    w(10);
    chk("after_rst_count", 32'(wr_count), 32'd0);
    wr_frame(8'h02, 8'h55);
    w(10);
    chk("post_rst_addr", 32'(reg_addr), 32'h01);
    chk("post_rst_data", 32'(reg_data), 32'h055);

    // 255 more writes take wr_count from 1 through 0xFF to 0x00
    for (int i = 0; i < 255; i++) begin
      logic [7:0] v;
      v = 8'(i);
      wr_frame(v, ~v);
    end
    w(10);
    chk("wrap", 32'(wr_count), 32'd0);

`ifdef I2C_GLITCH_FILTER_EN
    // 2-clk SCL spike inside byte 1 must not shift in a bit
    push_wr(8'hA6, 8'h3C);
    i2c_start();
    send_byte(8'h34, 1'b1, "ack_addr_gl");
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    w(2);
    scl_m = 1'b1;
    w(2);
    scl_m = 1'b0;
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    bit_out(1'b0);
    ack_slot(1'b1, "ack_b1_gl");
    send_byte(8'h3C, 1'b1, "ack_b2_gl");
    i2c_stop();
    w(10);
    chk("glitch_addr", 32'(reg_addr), 32'h53);
    chk("glitch_data", 32'(reg_data), 32'h03C);
`endif

    w(20);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
